fp_multiplier: RTL and testbench

FP_MULTIPLIER -- requirements
Module: fp_multiplier

---
 rtl/fixed_point_pkg.sv | 22 ++
 rtl/fp_multiplier_if.sv | 16 +
 rtl/fp_multiplier.sv | 147 ++++++++++++++
 tb/tb_fp_multiplier.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fixed_point_pkg.sv
// Shared Q-format parameters and saturation bounds for the fixed-point
// multicycle arithmetic blocks (multiplier and divider).
package fixed_point_pkg;

    parameter int unsigned FP_WIDTH = 32;
    parameter int unsigned FP_FBITS = 16;

    // Largest positive value representable in a w-bit two's complement word.
    function automatic logic [63:0] fp_max_pos(input int unsigned w);
        return (64'd1 << (w - 32'd1)) - 64'd1;
    endfunction

    // Magnitude of the most negative value representable in a w-bit word.
    function automatic logic [63:0] fp_min_neg_mag(input int unsigned w);
        return 64'd1 << (w - 32'd1);
    endfunction

    localparam logic [FP_WIDTH-1:0] FP_ONE     = FP_WIDTH'(64'd1 << FP_FBITS);
    localparam logic [FP_WIDTH-1:0] FP_MAX_POS = FP_WIDTH'(fp_max_pos(FP_WIDTH));
    localparam logic [FP_WIDTH-1:0] FP_MIN_NEG = FP_WIDTH'(fp_min_neg_mag(FP_WIDTH));

endpackage

// File: rtl/fp_multiplier_if.sv
// Start/done request bus shared by the multicycle ALU blocks.
interface fp_multiplier_if
    import fixed_point_pkg::*;
#(
    parameter int unsigned WIDTH = FP_WIDTH
) ();
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             start;
    logic [WIDTH-1:0] y;
    logic             done;
    logic             overflow;

    modport master (output a, output b, output start, input y, input done, input overflow);
    modport slave  (input a, input b, input start, output y, output done, output overflow);
endinterface

// File: rtl/fp_multiplier.sv
// Sequential signed fixed-point multiplier: sign-magnitude shift-add over
// WIDTH cycles, truncation toward zero, saturation on overflow.
module fp_multiplier
    import fixed_point_pkg::*;
#(
    parameter int unsigned WIDTH = FP_WIDTH,
    parameter int unsigned FBITS = FP_FBITS
) (
    input logic            clk,
    input logic            reset,
    fp_multiplier_if.slave bus
);
    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned MW = PW - FBITS;
    localparam int unsigned CW = $clog2(WIDTH);

    localparam logic [MW-1:0]    POS_BOUND = MW'(fp_max_pos(WIDTH));
    localparam logic [MW-1:0]    NEG_BOUND = MW'(fp_min_neg_mag(WIDTH));
    localparam logic [WIDTH-1:0] SAT_POS   = WIDTH'(fp_max_pos(WIDTH));
    localparam logic [WIDTH-1:0] SAT_NEG   = WIDTH'(fp_min_neg_mag(WIDTH));

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SIGN = 2'd2,
        DONE = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [PW-1:0]    mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sign_q, sign_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             done_q, done_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH-1:0] a_abs_s;
    logic [WIDTH-1:0] b_abs_s;
    logic [MW-1:0]    mag_s;

    // Magnitudes are WIDTH-bit unsigned, so the most negative operand keeps its full magnitude.
    assign a_abs_s = bus.a[WIDTH-1] ? (~bus.a + WIDTH'(1)) : bus.a;
    assign b_abs_s = bus.b[WIDTH-1] ? (~bus.b + WIDTH'(1)) : bus.b;
    assign mag_s   = acc_q[PW-1:FBITS];

    // Next-state and datapath control.
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        sign_d   = sign_q;
        y_d      = y_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if ((bus.a != WIDTH'(0)) && (bus.b != WIDTH'(0))) begin
                        mcand_d  = {{WIDTH{1'b0}}, a_abs_s};
                        mplier_d = b_abs_s;
                        sign_d   = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
                        acc_d    = '0;
                        cnt_d    = '0;
                        state_d  = CALC;
                    end else begin
                        y_d     = '0;
                        ovf_d   = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end else begin
                    acc_d = acc_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = SIGN;
                end else begin
                    state_d = CALC;
                end
            end
            SIGN: begin
                if (!sign_q && (mag_s > POS_BOUND)) begin
                    y_d   = SAT_POS;
                    ovf_d = 1'b1;
                end else if (sign_q && (mag_s > NEG_BOUND)) begin
                    y_d   = SAT_NEG;
                    ovf_d = 1'b1;
                end else begin
                    y_d   = sign_q ? (WIDTH'(0) - mag_s[WIDTH-1:0]) : mag_s[WIDTH-1:0];
                    ovf_d = 1'b0;
                end
                state_d = DONE;
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            sign_q   <= 1'b0;
            y_q      <= '0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            sign_q   <= sign_d;
            y_q      <= y_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.y        = y_q;
    assign bus.done     = done_q;
    assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_fp_multiplier.sv
// Scoreboard bench for fp_multiplier: expected Q16.16 products come from a
// 64-bit signed reference model and are popped when done pulses.
module tb_fp_multiplier;

    typedef struct packed {
        logic [31:0] y;
        logic        ovf;
    } exp_t;

    logic clk;
    logic reset;
    int   check_cnt;
    int   pass_cnt;
    exp_t sb[$];

    fp_multiplier_if bus ();

    fp_multiplier dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
        exp_t   e;
        longint p;
        longint q;
        p = longint'($signed(a)) * longint'($signed(b));
        q = p / 64'sd65536;
        if (q > 64'sd2147483647) begin
            e.y = 32'h7FFF_FFFF; e.ovf = 1'b1;
        end else if (q < -64'sd2147483648) begin
            e.y = 32'h8000_0000; e.ovf = 1'b1;
        end else begin
            e.y = q[31:0]; e.ovf = 1'b0;
        end
        return e;
    endfunction

    // Drive a one-cycle start at a negedge; returns at the negedge after the sampling edge.
    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.a = a; bus.b = b; bus.start = 1'b1;
        sb.push_back(model(a, b));
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Counts negedges since the sampling edge until done is seen, bounded.
    task automatic wait_done(input int n0, output int lat, output bit seen);
        int n;
        n = n0; seen = 1'b0; lat = -1;
        while (n < 80 && !seen) begin
            if (bus.done === 1'b1) begin
                seen = 1'b1; lat = n;
            end else begin
                @(negedge clk);
                n++;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_cnt++;
        if (bus.y !== 32'h0) $display("FAIL reset_y: got %h want 00000000", bus.y);
        else pass_cnt++;
        check_cnt++;
        if (bus.done !== 1'b0) $display("FAIL reset_done: got %b want 0", bus.done);
        else pass_cnt++;
        check_cnt++;
        if (bus.overflow !== 1'b0) $display("FAIL reset_ovf: got %b want 0", bus.overflow);
        else pass_cnt++;
        reset = 1'b0;
    endtask

    task automatic test_basic();
        logic [31:0] av [4] = '{32'h0001_8000, 32'hFFFE_8000, 32'hFFFE_8000, 32'h0001_0000};
        logic [31:0] bv [4] = '{32'h0002_0000, 32'h0002_0000, 32'hFFFE_0000, 32'h0003_4000};
        exp_t e; int lat; bit seen;
        for (int i = 0; i < 4; i++) begin
            issue(av[i], bv[i]);
            wait_done(0, lat, seen);
            e = sb.pop_front();
            check_cnt++;
            if (!seen || lat != 34) $display("FAIL basic_latency[%0d]: got %0d want 34", i, lat);
            else pass_cnt++;
            check_cnt++;
            if (bus.y !== e.y) $display("FAIL basic_y[%0d]: got %h want %h", i, bus.y, e.y);
            else pass_cnt++;
            check_cnt++;
            if (bus.overflow !== e.ovf) $display("FAIL basic_ovf[%0d]: got %b want %b", i, bus.overflow, e.ovf);
            else pass_cnt++;
            @(negedge clk);
            check_cnt++;
            if (bus.done !== 1'b0) $display("FAIL basic_done_width[%0d]: got %b want 0", i, bus.done);
            else pass_cnt++;
        end
    endtask

    task automatic test_boundaries();
        logic [31:0] av [5] = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h0100_0000, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] bv [5] = '{32'h0000_8000, 32'h0000_8000, 32'h0100_0000, 32'h0001_0000, 32'h0002_0000};
        exp_t e; int lat; bit seen;
        for (int i = 0; i < 5; i++) begin
            issue(av[i], bv[i]);
            wait_done(0, lat, seen);
            e = sb.pop_front();
            check_cnt++;
            if (!seen || lat != 34) $display("FAIL bound_latency[%0d]: got %0d want 34", i, lat);
            else pass_cnt++;
            check_cnt++;
            if (bus.y !== e.y) $display("FAIL bound_y[%0d]: got %h want %h", i, bus.y, e.y);
            else pass_cnt++;
            check_cnt++;
            if (bus.overflow !== e.ovf) $display("FAIL bound_ovf[%0d]: got %b want %b", i, bus.overflow, e.ovf);
            else pass_cnt++;
        end
    endtask

    task automatic test_zero();
        exp_t e; int lat; bit seen;
        issue(32'h0000_0000, 32'h1234_5678);
        wait_done(0, lat, seen);
        e = sb.pop_front();
        check_cnt++;
        if (!seen || lat != 0) $display("FAIL zero_latency: got %0d want 0", lat);
        else pass_cnt++;
        check_cnt++;
        if (bus.y !== e.y) $display("FAIL zero_y: got %h want %h", bus.y, e.y);
        else pass_cnt++;
        check_cnt++;
        if (bus.overflow !== e.ovf) $display("FAIL zero_ovf: got %b want %b", bus.overflow, e.ovf);
        else pass_cnt++;
    endtask

    task automatic test_ignore_start();
        exp_t e; int lat; bit seen;
        issue(32'h0002_8000, 32'hFFFD_0000);
        repeat (5) @(negedge clk);
        bus.a = 32'h7FFF_0000; bus.b = 32'h7FFF_0000; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; bus.a = 32'h0000_0000; bus.b = 32'h0012_3400;
        wait_done(6, lat, seen);
        e = sb.pop_front();
        check_cnt++;
        if (!seen || lat != 34) $display("FAIL ignore_latency: got %0d want 34", lat);
        else pass_cnt++;
        check_cnt++;
        if (bus.y !== e.y) $display("FAIL ignore_y: got %h want %h", bus.y, e.y);
        else pass_cnt++;
        @(negedge clk);
        repeat (40) begin
            if (bus.done === 1'b1) seen = 1'b0;
            @(negedge clk);
        end
        check_cnt++;
        if (!seen) $display("FAIL ignore_extra_done: got a second done want none");
        else pass_cnt++;
    endtask

    task automatic test_reset_abort();
        exp_t e; int lat; bit seen; bit spurious;
        issue(32'h0003_0000, 32'h0004_0000);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        e = sb.pop_front();
        check_cnt++;
        if (bus.y !== 32'h0) $display("FAIL abort_y: got %h want 00000000", bus.y);
        else pass_cnt++;
        spurious = 1'b0;
        repeat (50) begin
            if (bus.done === 1'b1) spurious = 1'b1;
            @(negedge clk);
        end
        check_cnt++;
        if (spurious) $display("FAIL abort_done: got done pulse want none");
        else pass_cnt++;
        issue(32'hFFFF_4000, 32'h0006_0000);
        wait_done(0, lat, seen);
        e = sb.pop_front();
        check_cnt++;
        if (!seen || lat != 34) $display("FAIL abort_fresh_latency: got %0d want 34", lat);
        else pass_cnt++;
        check_cnt++;
        if (bus.y !== e.y) $display("FAIL abort_fresh_y: got %h want %h", bus.y, e.y);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        exp_t e; int lat; bit seen;
        issue(32'h0001_8000, 32'h0001_8000);
        wait_done(0, lat, seen);
        bus.a = 32'hFFFF_0000; bus.b = 32'h0005_8000; bus.start = 1'b1;
        sb.push_back(model(32'hFFFF_0000, 32'h0005_8000));
        e = sb.pop_front();
        check_cnt++;
        if (!seen || bus.y !== e.y) $display("FAIL b2b_first_y: got %h want %h", bus.y, e.y);
        else pass_cnt++;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(0, lat, seen);
        e = sb.pop_front();
        check_cnt++;
        if (!seen || lat != 34) $display("FAIL b2b_second_latency: got %0d want 34", lat);
        else pass_cnt++;
        check_cnt++;
        if (bus.y !== e.y) $display("FAIL b2b_second_y: got %h want %h", bus.y, e.y);
        else pass_cnt++;
    endtask

    task automatic test_random();
        exp_t e; int lat; bit seen; logic [31:0] a; logic [31:0] b;
        for (int i = 0; i < 8; i++) begin
            a = (i < 4) ? {{12{$urandom_range(1, 0) == 1}}, 20'($urandom)} : 32'($urandom);
            b = (i < 4) ? {{12{$urandom_range(1, 0) == 1}}, 20'($urandom)} : 32'($urandom);
            issue(a, b);
            wait_done(0, lat, seen);
            e = sb.pop_front();
            check_cnt++;
            if (!seen || bus.y !== e.y) $display("FAIL rand_y[%0d]: a=%h b=%h got %h want %h", i, a, b, bus.y, e.y);
            else pass_cnt++;
            check_cnt++;
            if (bus.overflow !== e.ovf) $display("FAIL rand_ovf[%0d]: a=%h b=%h got %b want %b", i, a, b, bus.overflow, e.ovf);
            else pass_cnt++;
        end
    endtask

    initial begin
        clk = 1'b0; reset = 1'b1;
        bus.a = 32'h0; bus.b = 32'h0; bus.start = 1'b0;
        check_cnt = 0; pass_cnt = 0;
        test_reset();
        test_basic();
        test_boundaries();
        test_zero();
        test_ignore_start();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
